// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES CBC chaining stage
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DRAIN = 3'd4
  } chain_state_e;

endpackage

// File: rtl/aes_cbc_chainer.sv
// rtl/aes_cbc_chainer.sv - CBC chaining stage between word stacker and AES core (optional ECB via AES_CBC_ECB_MODE_EN)
module aes_cbc_chainer
  import aes_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               enable_i,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic               iv_load_i,
  input  logic               pt_valid_i,
  output logic               pt_ready_o,
  input  logic [BLOCK_W-1:0] pt_i,
  output logic               core_valid_o,
  input  logic               core_ready_i,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic               ct_valid_i,
  output logic               ct_ready_o,
  input  logic [BLOCK_W-1:0] ct_i,
`ifdef AES_CBC_ECB_MODE_EN
  input  logic               ecb_i,
`endif
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BLOCK_W-1:0] word_o,
  output logic [CNT_W-1:0]   blocks_o
);

  chain_state_e r_state;
  chain_state_e w_state_nxt;

  logic [BLOCK_W-1:0] r_chain;
  logic [BLOCK_W-1:0] r_xor;
  logic [BLOCK_W-1:0] r_out;
  logic [CNT_W-1:0]   r_blocks;
`ifdef AES_CBC_ECB_MODE_EN
  logic               r_ecb;
`endif

  // Handshakes may only happen when the block is running and not being cleared.
  logic w_active;
  logic w_pt_fire;
  logic w_core_fire;
  logic w_ct_fire;
  logic w_out_fire;
  logic w_iv_load;
  logic [BLOCK_W-1:0] w_chain;

  assign w_active    = enable_i & ~clr_i & ~rst_i;
  assign w_pt_fire   = pt_ready_o & pt_valid_i;
  assign w_core_fire = core_valid_o & core_ready_i;
  assign w_ct_fire   = ct_ready_o & ct_valid_i;
  assign w_out_fire  = valid_o & ready_i;
  assign w_iv_load   = w_active & (r_state == IDLE) & iv_load_i;

  // Chain value used for the XOR: a same-cycle IV load takes effect immediately.
  always_comb begin
    w_chain = w_iv_load ? iv_i : r_chain;
`ifdef AES_CBC_ECB_MODE_EN
    if (ecb_i) begin
      w_chain = '0;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs; outputs depend only on state and enables.
  always_comb begin
    w_state_nxt  = r_state;
    pt_ready_o   = 1'b0;
    core_valid_o = 1'b0;
    ct_ready_o   = 1'b0;
    valid_o      = 1'b0;

    if (w_active) begin
      case (r_state)
        IDLE:    pt_ready_o   = 1'b1;
        SEND:    core_valid_o = 1'b1;
        WAIT:    ct_ready_o   = 1'b1;
        OUT:     valid_o      = 1'b1;
        DRAIN:   ct_ready_o   = 1'b1;
        default: ;
      endcase
    end

    if (clr_i) begin
      // A block already taken by the core must have its ciphertext absorbed.
      if (r_state == WAIT || r_state == DRAIN) begin
        w_state_nxt = DRAIN;
      end else begin
        w_state_nxt = IDLE;
      end
    end else if (enable_i) begin
      case (r_state)
        IDLE:    if (w_pt_fire)   w_state_nxt = SEND;
        SEND:    if (w_core_fire) w_state_nxt = WAIT;
        WAIT:    if (w_ct_fire)   w_state_nxt = OUT;
        OUT:     if (w_out_fire)  w_state_nxt = IDLE;
        DRAIN:   if (w_ct_fire)   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: IV load, XOR capture, ciphertext capture and delivered-block counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chain  <= '0;
      r_xor    <= '0;
      r_out    <= '0;
      r_blocks <= '0;
`ifdef AES_CBC_ECB_MODE_EN
      r_ecb    <= 1'b0;
`endif
    end else if (clr_i) begin
      r_chain  <= '0;
      r_xor    <= '0;
      r_out    <= '0;
      r_blocks <= '0;
`ifdef AES_CBC_ECB_MODE_EN
      r_ecb    <= 1'b0;
`endif
    end else begin
      if (w_iv_load) begin
        r_chain <= iv_i;
      end
      if (w_pt_fire) begin
        r_xor <= pt_i ^ w_chain;
`ifdef AES_CBC_ECB_MODE_EN
        r_ecb <= ecb_i;
`endif
      end
      if (w_ct_fire && r_state == WAIT) begin
        r_out <= ct_i;
`ifdef AES_CBC_ECB_MODE_EN
        if (!r_ecb) begin
          r_chain <= ct_i;
        end
`else
        r_chain <= ct_i;
`endif
      end
      if (w_out_fire) begin
        r_blocks <= r_blocks + CNT_W'(1);
      end
    end
  end

  assign core_data_o = r_xor;
  assign word_o      = r_out;
  assign blocks_o    = r_blocks;

endmodule

// File: tb/tb_aes_cbc_chainer.sv
// tb/tb_aes_cbc_chainer.sv - scoreboard bench for aes_cbc_chainer with an echoing 2-cycle core model
module tb_aes_cbc_chainer;

  localparam int BW = 128;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          enable_i = 1'b1;
  logic [BW-1:0] iv_i = '0;
  logic          iv_load_i = 1'b0;
  logic          pt_valid_i = 1'b0;
  logic          pt_ready_o;
  logic [BW-1:0] pt_i = '0;
  logic          core_valid_o;
  logic          core_ready_i = 1'b1;
  logic [BW-1:0] core_data_o;
  logic          ct_valid_i = 1'b0;
  logic          ct_ready_o;
  logic [BW-1:0] ct_i = '0;
`ifdef AES_CBC_ECB_MODE_EN
  logic          ecb_i = 1'b0;
`endif
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [BW-1:0] word_o;
  logic [CW-1:0] blocks_o;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] exp_core[$];
  logic [BW-1:0] exp_word[$];
  logic [CW-1:0] exp_blk[$];

  bit            ct_override = 1'b0;
  logic [BW-1:0] ct_ov_val = '0;

  always #5 clk_i = ~clk_i;

  aes_cbc_chainer #(.BLOCK_W(BW), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (clr_i),
    .enable_i     (enable_i),
    .iv_i         (iv_i),
    .iv_load_i    (iv_load_i),
    .pt_valid_i   (pt_valid_i),
    .pt_ready_o   (pt_ready_o),
    .pt_i         (pt_i),
    .core_valid_o (core_valid_o),
    .core_ready_i (core_ready_i),
    .core_data_o  (core_data_o),
    .ct_valid_i   (ct_valid_i),
    .ct_ready_o   (ct_ready_o),
    .ct_i         (ct_i),
`ifdef AES_CBC_ECB_MODE_EN
    .ecb_i        (ecb_i),
`endif
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .word_o       (word_o),
    .blocks_o     (blocks_o)
  );

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event", name);
  endtask

  // Core model: echoes each accepted block as ciphertext two cycles later.
  initial begin : core_model
    logic [BW-1:0] d;
    int k;
    forever begin
      @(negedge clk_i);
      if (!rst_i && core_valid_o && core_ready_i) begin
        d = core_data_o;
        @(posedge clk_i);
        repeat (2) @(posedge clk_i);
        #1;
        ct_valid_i = 1'b1;
        ct_i = ct_override ? ct_ov_val : d;
        k = 0;
        while (k < 500) begin
          @(negedge clk_i);
          if (ct_ready_o) break;
          k++;
        end
        @(posedge clk_i);
        #1 ct_valid_i = 1'b0;
      end
    end
  end

  // Monitor: pops and compares whenever a handshake is about to complete.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (core_valid_o && core_ready_i) begin
        if (exp_core.size() == 0) fail_now("core_unexpected");
        else chk("core_data", core_data_o, exp_core.pop_front());
      end
      if (valid_o && ready_i) begin
        if (exp_word.size() == 0) fail_now("word_unexpected");
        else begin
          chk("word_o", word_o, exp_word.pop_front());
          chk("blocks_before", BW'(blocks_o), BW'(exp_blk.pop_front()));
        end
      end
    end
  end

  task automatic push(input logic [BW-1:0] c, input logic [BW-1:0] w, input logic [CW-1:0] b);
    exp_core.push_back(c);
    exp_word.push_back(w);
    exp_blk.push_back(b);
  endtask

  task automatic send(input logic [BW-1:0] pt, input bit ld, input logic [BW-1:0] iv);
    int n;
    @(posedge clk_i);
    #1;
    pt_i = pt;
    pt_valid_i = 1'b1;
    iv_load_i = ld;
    iv_i = iv;
    n = 0;
    @(negedge clk_i);
    while (!pt_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!pt_ready_o) fail_now("pt_accept_timeout");
    @(posedge clk_i);
    #1;
    pt_valid_i = 1'b0;
    iv_load_i = 1'b0;
  endtask

  task automatic wait_blocks(input string name, input logic [CW-1:0] n);
    int k;
    k = 0;
    while (blocks_o !== n && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk(name, BW'(blocks_o), BW'(n));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    bit seen;

    // Reset state
    #12;
    chk("rst_pt_ready", BW'(pt_ready_o), BW'(0));
    chk("rst_core_valid", BW'(core_valid_o), BW'(0));
    chk("rst_ct_ready", BW'(ct_ready_o), BW'(0));
    chk("rst_valid", BW'(valid_o), BW'(0));
    chk("rst_core_data", core_data_o, '0);
    chk("rst_word", word_o, '0);
    chk("rst_blocks", BW'(blocks_o), BW'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_pt_ready", BW'(pt_ready_o), BW'(1));

    // IV=0, plaintext AA passes through unchanged
    push({16{8'hAA}}, {16{8'hAA}}, 16'd0);
    send({16{8'hAA}}, 1'b1, '0);
    wait_blocks("blocks_t1", 16'd1);

    // IV 0F, two FF blocks chained
    push({16{8'hF0}}, {16{8'hF0}}, 16'd1);
    send({16{8'hFF}}, 1'b1, {16{8'h0F}});
    wait_blocks("blocks_t2a", 16'd2);
    push({16{8'h0F}}, {16{8'h0F}}, 16'd2);
    send({16{8'hFF}}, 1'b0, '0);
    wait_blocks("blocks_t2b", 16'd3);

    // Back-pressure in OUT
    ready_i = 1'b0;
    push({16{8'h0F}}, {16{8'h0F}}, 16'd3);
    send('0, 1'b0, '0);
    k = 0;
    while (!valid_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", BW'(valid_o), BW'(1));
      chk("stall_word", word_o, {16{8'h0F}});
      chk("stall_pt_ready", BW'(pt_ready_o), BW'(0));
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    wait_blocks("blocks_stall", 16'd4);
    repeat (5) @(negedge clk_i);
    chk("blocks_once", BW'(blocks_o), BW'(4));

    // Clear while waiting on the core: ciphertext is drained, not output
    ct_override = 1'b1;
    ct_ov_val = {8{16'h1234}};
    exp_core.push_back({16{8'h0F}});
    send('0, 1'b0, '0);
    k = 0;
    @(negedge clk_i);
    while (!ct_ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    @(posedge clk_i);
    #1 clr_i = 1'b1;
    @(posedge clk_i);
    #1 clr_i = 1'b0;
    @(negedge clk_i);
    chk("drain_ct_ready", BW'(ct_ready_o), BW'(1));
    chk("drain_pt_ready", BW'(pt_ready_o), BW'(0));
    chk("drain_blocks", BW'(blocks_o), BW'(0));
    chk("drain_word", word_o, '0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid_o) seen = 1'b1;
      @(negedge clk_i);
    end
    chk("drain_no_valid", BW'(seen), BW'(0));
    chk("drain_back_idle", BW'(pt_ready_o), BW'(1));
    ct_override = 1'b0;
    push({16{8'h55}}, {16{8'h55}}, 16'd0);
    send({16{8'h55}}, 1'b0, '0);
    wait_blocks("blocks_after_clr", 16'd1);

    // Same-cycle IV load and plaintext
    push(128'h2, 128'h2, 16'd1);
    send(128'h3, 1'b1, 128'h1);
    wait_blocks("blocks_iv", 16'd2);

    // Enable low freezes handshakes
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    @(negedge clk_i);
    chk("disabled_pt_ready", BW'(pt_ready_o), BW'(0));
    @(posedge clk_i);
    #1 enable_i = 1'b1;
    @(negedge clk_i);
    chk("enabled_pt_ready", BW'(pt_ready_o), BW'(1));

`ifdef AES_CBC_ECB_MODE_EN
    ecb_i = 1'b1;
    push({16{8'hBB}}, {16{8'hBB}}, 16'd2);
    send({16{8'hBB}}, 1'b0, '0);
    wait_blocks("blocks_ecb1", 16'd3);
    push({16{8'hBB}}, {16{8'hBB}}, 16'd3);
    send({16{8'hBB}}, 1'b0, '0);
    wait_blocks("blocks_ecb2", 16'd4);
    ecb_i = 1'b0;
`endif

    k = 0;
    while ((exp_core.size() != 0 || exp_word.size() != 0) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("core_queue_empty", BW'(exp_core.size()), BW'(0));
    chk("word_queue_empty", BW'(exp_word.size()), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
